mod_counter: RTL

Parametrised modulo counter, the next generation of the team's 3-bit free-running counter. It adds configurable width and terminal value, up/down/bounce modes, and wrap or saturate behaviour. It also adds synchronous clear, parallel load, count enable, a terminal-count pulse and a sticky overflow flag. Used as a general timebase/sequence generator feeding FSMs and strobe logic in the rest of the design.

---
 rtl/mod_counter_if.sv | 14 +
 rtl/mod_counter.sv | 82 ++++++++
 2 files changed

// File: rtl/mod_counter_if.sv
// mod_counter_if: control inputs and status outputs of mod_counter.
interface mod_counter_if #(parameter int WIDTH = 3);
   logic             clr;
   logic             load;
   logic [WIDTH-1:0] load_val;
   logic             en;
   logic [1:0]       mode;
   logic [WIDTH-1:0] count;
   logic             dir;
   logic             tc;
   logic             ovf;
   modport master (output clr, load, load_val, en, mode, input count, dir, tc, ovf);
   modport slave (input clr, load, load_val, en, mode, output count, dir, tc, ovf);
endinterface

// File: rtl/mod_counter.sv
// mod_counter: modulo counter with up/down/bounce modes, wrap or saturate,
// clear/load/enable, terminal-count pulse and sticky overflow.
module mod_counter #(
   parameter int WIDTH    = 3,
   parameter int MAX      = 7,
   parameter bit SATURATE = 1'b0
) (
   input logic          clk_i,
   input logic          rst_ni,
   mod_counter_if.slave bus
);
   typedef enum logic [1:0] {M_UP = 2'b00, M_DOWN = 2'b01, M_BOUNCE = 2'b10, M_HOLD = 2'b11} mode_e;
   typedef enum logic {D_UP = 1'b0, D_DOWN = 1'b1} dir_e;
   localparam logic [WIDTH-1:0] TOP = WIDTH'(MAX);
   localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
   generate
      if (WIDTH < 1 || MAX < 1 || 64'(MAX) >= (64'd1 << WIDTH)) begin : g_bad_param
         $error("mod_counter: MAX must lie in 1 .. 2**WIDTH-1");
      end
   endgenerate
   logic [WIDTH-1:0] count_q, count_d;
   dir_e             dir_q, dir_d;
   logic             tc_q, tc_d;
   logic             ovf_q, ovf_d;
   logic             at_top, at_zero, turn, step_up;
   mode_e            mode;
   assign mode    = mode_e'(bus.mode);
   assign at_top  = count_q == TOP;
   assign at_zero = count_q == '0;
   // Bounce reverses on reaching an end and steps straight back off it.
   assign turn    = (dir_q == D_UP) ? at_top : at_zero;
   assign step_up = (dir_q == D_UP) ^ turn;
   always_comb begin
      count_d = count_q;
      dir_d   = dir_q;
      tc_d    = 1'b0;
      ovf_d   = ovf_q;
      if (bus.clr) begin
         count_d = '0;
         dir_d   = D_UP;
         ovf_d   = 1'b0;
      end else if (bus.load) begin
         count_d = (bus.load_val > TOP) ? TOP : bus.load_val;
      end else if (bus.en) begin
         case (mode)
            M_UP: begin
               count_d = at_top ? (SATURATE ? TOP : '0) : count_q + ONE;
               tc_d    = at_top;
               ovf_d   = ovf_q | at_top;
            end
            M_DOWN: begin
               count_d = at_zero ? (SATURATE ? '0 : TOP) : count_q - ONE;
               tc_d    = at_zero;
               ovf_d   = ovf_q | at_zero;
            end
            M_BOUNCE: begin
               count_d = step_up ? count_q + ONE : count_q - ONE;
               dir_d   = turn ? dir_e'(~dir_q) : dir_q;
               tc_d    = turn;
            end
            default: ;
         endcase
      end
   end
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         count_q <= '0;
         dir_q   <= D_UP;
         tc_q    <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         count_q <= count_d;
         dir_q   <= dir_d;
         tc_q    <= tc_d;
         ovf_q   <= ovf_d;
      end
   end
   assign bus.count = count_q;
   assign bus.dir   = dir_q;
   assign bus.tc    = tc_q;
   assign bus.ovf   = ovf_q;
endmodule
